// File: rtl/minmax_job_scheduler.sv
// Round-robin scheduler that shares a single signed min/max search engine
// between N_REQ requesters. Each job streams a block of samples out of the
// shared sample RAM and reports the extreme values tagged with the owner id.
module minmax_job_scheduler #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_base,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        ack,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [WIDTH-1:0]        mem_rdata,
  output logic                    busy,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [WIDTH-1:0]        resp_min,
  output logic [WIDTH-1:0]        resp_max,
  output logic                    resp_empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, state_n;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  job_id;
  logic [LEN_W-1:0] remain, remain_n;

  logic             any_req;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  cand_id;
  int               cand;
  logic [ADDR_W-1:0] pick_base;
  logic [LEN_W-1:0] pick_len;

  logic [N_REQ-1:0]  ack_n;
  logic              rd_en_n;
  logic [ADDR_W-1:0] addr_n;
  logic              resp_valid_n;
  logic              load_job;
  logic              finish_empty;
  logic              finish_data;

  logic                    valid_d;
  logic                    have_sample;
  logic signed [WIDTH-1:0] sample;
  logic signed [WIDTH-1:0] cur_min, cur_max;
  logic signed [WIDTH-1:0] nxt_min, nxt_max;

  assign sample    = mem_rdata;
  assign pick_base = req_base[pick_id*ADDR_W +: ADDR_W];
  assign pick_len  = req_len[pick_id*LEN_W +: LEN_W];

  // Round-robin arbiter: first requester at or after the pointer wins.
  always_comb begin
    any_req = 1'b0;
    pick_id = '0;
    cand    = 0;
    cand_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_id = ID_W'(cand);
      if (!any_req && req[cand_id]) begin
        any_req = 1'b1;
        pick_id = cand_id;
      end
    end
  end

  // Running signed min/max including the sample currently on the read bus.
  always_comb begin
    nxt_min = cur_min;
    nxt_max = cur_max;
    if (valid_d) begin
      if (!have_sample) begin
        nxt_min = sample;
        nxt_max = sample;
      end else begin
        if (sample < cur_min) nxt_min = sample;
        if (sample > cur_max) nxt_max = sample;
      end
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_n      = state;
    ack_n        = '0;
    rd_en_n      = 1'b0;
    addr_n       = mem_addr;
    remain_n     = remain;
    resp_valid_n = 1'b0;
    load_job     = 1'b0;
    finish_empty = 1'b0;
    finish_data  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          load_job       = 1'b1;
          ack_n[pick_id] = 1'b1;
          if (pick_len != '0) begin
            state_n  = ISSUE;
            rd_en_n  = 1'b1;
            addr_n   = pick_base;
            remain_n = pick_len - LEN_W'(1);
          end else begin
            state_n      = DONE;
            resp_valid_n = 1'b1;
            finish_empty = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (remain == '0) begin
          state_n = DRAIN;
        end else begin
          rd_en_n  = 1'b1;
          addr_n   = mem_addr + ADDR_W'(1);
          remain_n = remain - LEN_W'(1);
        end
      end
      DRAIN: begin
        state_n      = DONE;
        resp_valid_n = 1'b1;
        finish_data  = 1'b1;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Handshake, read-port and sequencing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack        <= '0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      remain     <= '0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      ptr        <= '0;
      job_id     <= '0;
    end else begin
      ack        <= ack_n;
      mem_rd_en  <= rd_en_n;
      mem_addr   <= addr_n;
      remain     <= remain_n;
      busy       <= (state_n != IDLE);
      resp_valid <= resp_valid_n;
      if (load_job) begin
        job_id <= pick_id;
        ptr    <= (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + ID_W'(1);
      end
    end
  end

  // Capture pipeline: read data is valid the cycle after each read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d     <= 1'b0;
      have_sample <= 1'b0;
      cur_min     <= '0;
      cur_max     <= '0;
    end else begin
      valid_d <= mem_rd_en;
      if (load_job) begin
        have_sample <= 1'b0;
      end else if (valid_d) begin
        have_sample <= 1'b1;
        cur_min     <= nxt_min;
        cur_max     <= nxt_max;
      end
    end
  end

  // Result registers hold until the next completed job overwrites them.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_id    <= '0;
      resp_min   <= '0;
      resp_max   <= '0;
      resp_empty <= 1'b0;
    end else if (finish_empty) begin
      resp_id    <= pick_id;
      resp_min   <= '0;
      resp_max   <= '0;
      resp_empty <= 1'b1;
    end else if (finish_data) begin
      resp_id    <= job_id;
      resp_min   <= nxt_min;
      resp_max   <= nxt_max;
      resp_empty <= 1'b0;
    end
  end

endmodule

// File: tb/tb_minmax_job_scheduler.sv
// Scoreboard bench for minmax_job_scheduler: jobs are predicted from a simple
// round-robin model and a RAM array, then checked by an independent monitor.
module tb_minmax_job_scheduler;

  localparam int N_REQ  = 4;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;
  localparam int ID_W   = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                    clk;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_base;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [N_REQ-1:0]        ack;
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [WIDTH-1:0]        mem_rdata;
  logic                    busy;
  logic                    resp_valid;
  logic [ID_W-1:0]         resp_id;
  logic [WIDTH-1:0]        resp_min;
  logic [WIDTH-1:0]        resp_max;
  logic                    resp_empty;

  minmax_job_scheduler #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_base(req_base), .req_len(req_len),
    .ack(ack), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .resp_valid(resp_valid), .resp_id(resp_id), .resp_min(resp_min),
    .resp_max(resp_max), .resp_empty(resp_empty)
  );

  typedef struct {
    int          id;
    logic [31:0] mn;
    logic [31:0] mx;
    logic        empty;
    int          lat;
  } exp_t;

  exp_t        expResp[$];
  int          expAck[$];
  int          expAddr[$];
  logic [31:0] ram [DEPTH];
  int          jobBase [N_REQ];
  int          jobLen [N_REQ];
  int          ptrModel;
  int          checks;
  int          errors;
  int          cyc;
  int          ackCycle;

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample RAM with a one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event expected none", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents ack, a read or a result.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack != '0) begin
        if (expAck.size() == 0) flagFail("unexpected_ack");
        else begin
          int id;
          logic [3:0] oh;
          id = expAck.pop_front();
          oh = 4'b0001 << id;
          checkOutput("ack_onehot", 128'(ack), 128'(oh));
          checkOutput("busy_at_ack", 128'(busy), 128'(1));
        end
        ackCycle = cyc;
      end
      if (mem_rd_en) begin
        if (expAddr.size() == 0) flagFail("unexpected_read");
        else begin
          int a;
          a = expAddr.pop_front();
          checkOutput("mem_addr", 128'(mem_addr), 128'(a));
        end
      end
      if (resp_valid) begin
        if (expResp.size() == 0) flagFail("unexpected_resp");
        else begin
          exp_t e;
          e = expResp.pop_front();
          checkOutput("resp_id", 128'(resp_id), 128'(e.id));
          checkOutput("resp_min", 128'(resp_min), 128'(e.mn));
          checkOutput("resp_max", 128'(resp_max), 128'(e.mx));
          checkOutput("resp_empty", 128'(resp_empty), 128'(e.empty));
          checkOutput("resp_latency", 128'(cyc - ackCycle), 128'(e.lat));
          checkOutput("busy_at_resp", 128'(busy), 128'(1));
        end
      end
    end
  end

  // One clock step; requesters withdraw req once they see their ack.
  task automatic stepCycle();
    @(negedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) if (ack[i]) req[i] = 1'b0;
  endtask

  // Predicts grant order and per-job results, pushes them, then raises req.
  task automatic applyStimulus(input logic [3:0] mask);
    for (int i = 0; i < N_REQ; i++) begin
      req_base[i*ADDR_W +: ADDR_W] = ADDR_W'(jobBase[i]);
      req_len[i*LEN_W +: LEN_W]    = LEN_W'(jobLen[i]);
    end
    for (int j = 0; j < N_REQ; j++) begin
      int id;
      exp_t e;
      logic signed [31:0] s, mn, mx;
      id = (ptrModel + j) % N_REQ;
      if (mask[id]) begin
        mn = 0;
        mx = 0;
        for (int k = 0; k < jobLen[id]; k++) begin
          s = ram[(jobBase[id] + k) % DEPTH];
          if (k == 0 || s < mn) mn = s;
          if (k == 0 || s > mx) mx = s;
          expAddr.push_back((jobBase[id] + k) % DEPTH);
        end
        e.id    = id;
        e.mn    = mn;
        e.mx    = mx;
        e.empty = (jobLen[id] == 0);
        e.lat   = (jobLen[id] == 0) ? 0 : jobLen[id] + 1;
        expResp.push_back(e);
        expAck.push_back(id);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      int id;
      id = (ptrModel + N_REQ - 1 - j) % N_REQ;
      if (mask[id]) begin
        ptrModel = (id + 1) % N_REQ;
        break;
      end
    end
    req = mask;
  endtask

  // Waits, with a cycle budget, until every predicted job has been reported.
  task automatic waitDone();
    int budget;
    int n;
    budget = 100 + expAddr.size() + 8 * expResp.size();
    n = 0;
    while ((expResp.size() != 0 || expAck.size() != 0) && n < budget) begin
      stepCycle();
      n++;
    end
    if (expResp.size() != 0 || expAck.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got %0d pending jobs expected 0", expResp.size());
      expResp.delete();
      expAck.delete();
      expAddr.delete();
    end
    stepCycle();
  endtask

  task automatic fillRam();
    for (int i = 0; i < DEPTH; i++) begin
      case ($urandom_range(0, 9))
        0:       ram[i] = 32'h7FFF_FFFF;
        1:       ram[i] = 32'h8000_0000;
        default: ram[i] = $urandom;
      endcase
    end
  endtask

  task automatic setJob(input int i, input int b, input int l);
    jobBase[i] = b;
    jobLen[i]  = l;
  endtask

  initial begin
    logic [83:0] outs;
    checks   = 0;
    errors   = 0;
    ptrModel = 0;
    ackCycle = 0;
    reset    = 1'b1;
    req      = '0;
    req_base = '0;
    req_len  = '0;
    for (int i = 0; i < N_REQ; i++) setJob(i, 0, 0);
    fillRam();
    repeat (3) stepCycle();
    outs = {ack, mem_rd_en, mem_addr, busy, resp_valid, resp_id, resp_min, resp_max, resp_empty};
    checkOutput("reset_outputs", 128'(outs), 128'(0));
    reset = 1'b0;
    stepCycle();

    // Basic job on requester 0.
    ram[16] = 32'd5; ram[17] = 32'hFFFF_FFFD; ram[18] = 32'd12; ram[19] = 32'd7;
    setJob(0, 16, 4);
    applyStimulus(4'b0001);
    waitDone();

    // All requesters, then a sparse pair.
    for (int i = 0; i < N_REQ; i++) setJob(i, $urandom_range(0, DEPTH - 1), i + 1);
    applyStimulus(4'b1111);
    waitDone();
    applyStimulus(4'b0101);
    waitDone();

    // Empty job.
    setJob(2, 100, 0);
    applyStimulus(4'b0100);
    waitDone();

    // Address wrap.
    setJob(1, 10'h3FE, 4);
    applyStimulus(4'b0010);
    waitDone();

    // Signed extremes and single-sample job.
    ram[200] = 32'h7FFF_FFFF; ram[201] = 32'h8000_0000; ram[202] = 32'h0;
    ram[300] = 32'hFFFF_FFFE;
    setJob(2, 200, 3);
    setJob(3, 300, 1);
    applyStimulus(4'b1100);
    waitDone();

    // Long job re-reading wrapped addresses.
    setJob(0, 10'h200, 1030);
    applyStimulus(4'b0001);
    waitDone();

    // Randomised batches.
    for (int b = 0; b < 30; b++) begin
      fillRam();
      for (int i = 0; i < N_REQ; i++)
        setJob(i, $urandom_range(0, DEPTH - 1),
               ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 16));
      applyStimulus(4'($urandom_range(1, 15)));
      waitDone();
    end

    // Reset during the second read of a long job aborts it and clears the pointer.
    setJob(0, 50, 8);
    applyStimulus(4'b0001);
    for (int n = 0; n < 20 && expAck.size() != 0; n++) stepCycle();
    stepCycle();
    reset = 1'b1;
    expResp.delete();
    expAddr.delete();
    expAck.delete();
    stepCycle();
    outs = {ack, mem_rd_en, mem_addr, busy, resp_valid, resp_id, resp_min, resp_max, resp_empty};
    checkOutput("abort_outputs", 128'(outs), 128'(0));
    reset    = 1'b0;
    ptrModel = 0;
    repeat (12) stepCycle();
    setJob(1, 60, 2);
    setJob(2, 70, 3);
    applyStimulus(4'b0110);
    waitDone();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
